// File: rtl/clk_div_mon.sv
// Divided-clock monitor: rise/fall strobes, phase-length measurement and lock/error reporting.
// Define CLK_DIV_MON_STICKY_ERR_EN to make err hold until reset or en is dropped.
module clk_div_mon #(
    parameter int HIGH_CYC     = 4,
    parameter int LOW_CYC      = 4,
    parameter int CNT_W        = 8,
    parameter int LOCK_PERIODS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_in,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic             locked,
    output logic             err
);

    localparam int GOOD_W = (LOCK_PERIODS < 1) ? 1 : $clog2(LOCK_PERIODS + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  HIGH_EXP = CNT_W'(HIGH_CYC);
    localparam logic [CNT_W-1:0]  LOW_EXP  = CNT_W'(LOW_CYC);
    localparam logic [CNT_W-1:0]  HIGH_OVR = CNT_W'(HIGH_CYC + 1);
    localparam logic [CNT_W-1:0]  LOW_OVR  = CNT_W'(LOW_CYC + 1);
    localparam logic [GOOD_W-1:0] LOCK_CNT = GOOD_W'(LOCK_PERIODS);

    logic              prev_q,      prev_d;
    logic              primed_q,    primed_d;
    logic              armed_q,     armed_d;
    logic              high_ok_q,   high_ok_d;
    logic              phase_err_q, phase_err_d;
    logic [CNT_W-1:0]  run_cnt_q,   run_cnt_d;
    logic [GOOD_W-1:0] good_cnt_q,  good_cnt_d;
    logic              rise_q,      rise_d;
    logic              fall_q,      fall_d;
    logic [CNT_W-1:0]  high_len_q,  high_len_d;
    logic [CNT_W-1:0]  low_len_q,   low_len_d;
    logic              locked_q,    locked_d;
    logic              err_q,       err_d;
    logic              err_event;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        prev_d      = prev_q;
        primed_d    = primed_q;
        armed_d     = armed_q;
        high_ok_d   = high_ok_q;
        phase_err_d = phase_err_q;
        run_cnt_d   = run_cnt_q;
        good_cnt_d  = good_cnt_q;
        high_len_d  = high_len_q;
        low_len_d   = low_len_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        err_event   = 1'b0;

        if (!en) begin
            primed_d    = 1'b0;
            armed_d     = 1'b0;
            high_ok_d   = 1'b0;
            phase_err_d = 1'b0;
            run_cnt_d   = '0;
            good_cnt_d  = '0;
        end else if (!primed_q) begin
            prev_d    = div_in;
            primed_d  = 1'b1;
            run_cnt_d = CNT_ONE;
        end else if (div_in != prev_q) begin
            prev_d      = div_in;
            run_cnt_d   = CNT_ONE;
            rise_d      = div_in;
            fall_d      = ~div_in;
            phase_err_d = 1'b0;
            if (!armed_q) begin
                // The phase before the first edge is partial: arm only, measure nothing.
                armed_d   = 1'b1;
                high_ok_d = 1'b0;
            end else if (!div_in) begin
                high_len_d = run_cnt_q;
                high_ok_d  = (run_cnt_q == HIGH_EXP);
                if (run_cnt_q != HIGH_EXP && !phase_err_q) err_event = 1'b1;
            end else begin
                low_len_d = run_cnt_q;
                if (run_cnt_q == LOW_EXP) begin
                    if (high_ok_q && good_cnt_q != LOCK_CNT) good_cnt_d = good_cnt_q + 1'b1;
                end else if (!phase_err_q) begin
                    err_event = 1'b1;
                end
            end
        end else begin
            if (run_cnt_q != CNT_MAX) run_cnt_d = run_cnt_q + 1'b1;
            // Overrun fires once, on the sample that makes the phase one too long.
            if (armed_q && !phase_err_q && run_cnt_d == (prev_q ? HIGH_OVR : LOW_OVR)) begin
                err_event   = 1'b1;
                phase_err_d = 1'b1;
            end
        end

        if (err_event) begin
            good_cnt_d = '0;
            high_ok_d  = 1'b0;
        end

        locked_d = (good_cnt_d == LOCK_CNT);
`ifdef CLK_DIV_MON_STICKY_ERR_EN
        err_d = en & (err_q | err_event);
`else
        err_d = err_event;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q      <= 1'b0;
            primed_q    <= 1'b0;
            armed_q     <= 1'b0;
            high_ok_q   <= 1'b0;
            phase_err_q <= 1'b0;
            run_cnt_q   <= '0;
            good_cnt_q  <= '0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            high_len_q  <= '0;
            low_len_q   <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all state updates from the same pre-edge values.
            prev_q      <= prev_d;
            primed_q    <= primed_d;
            armed_q     <= armed_d;
            high_ok_q   <= high_ok_d;
            phase_err_q <= phase_err_d;
            run_cnt_q   <= run_cnt_d;
            good_cnt_q  <= good_cnt_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            high_len_q  <= high_len_d;
            low_len_q   <= low_len_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    assign rise     = rise_q;
    assign fall     = fall_q;
    assign high_len = high_len_q;
    assign low_len  = low_len_q;
    assign locked   = locked_q;
    assign err      = err_q;

endmodule
